// File: rtl/pla_pkg.sv
// Shared types and default sizes for the sequential PLA evaluator.
package pla_pkg;

    localparam int N_IN_DEF   = 15;
    localparam int N_CUBE_DEF = 16;
    localparam int N_OUT_DEF  = 1;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    // Cube table entry at the default sizes; instances with other widths use the same field order.
    typedef struct packed {
        logic                 en;
        logic [N_IN_DEF-1:0]  care;
        logic [N_IN_DEF-1:0]  val;
        logic [N_OUT_DEF-1:0] out;
    } cube_t;

endpackage

// File: rtl/pla_cube_match.sv
// Single-cube match: contributes the cube's output mask when every cared literal agrees with x.
module pla_cube_match
    import pla_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF
) (
    input  logic             en,
    input  logic [N_IN-1:0]  care,
    input  logic [N_IN-1:0]  val,
    input  logic [N_OUT-1:0] out,
    input  logic [N_IN-1:0]  x,
    output logic [N_OUT-1:0] contrib
);

    logic match;

    assign match   = en & (&(~care | ~(x ^ val)));
    assign contrib = match ? out : '0;

endmodule

// File: rtl/pla_seq_eval.sv
// Sequential sum-of-products evaluator: scans a writable cube table one entry per cycle,
// stopping early once every output is set, with valid/ready handshakes on input and result.
module pla_seq_eval
    import pla_pkg::*;
#(
    parameter int  N_IN   = N_IN_DEF,
    parameter int  N_CUBE = N_CUBE_DEF,
    parameter int  N_OUT  = N_OUT_DEF,
    localparam int ADDR_W = $clog2(N_CUBE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cube_we,
    input  logic [ADDR_W-1:0] cube_addr,
    input  logic              cube_en,
    input  logic [N_IN-1:0]   cube_care,
    input  logic [N_IN-1:0]   cube_val,
    input  logic [N_OUT-1:0]  cube_out,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   x,
    input  logic [N_OUT-1:0]  out_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  y,
    output logic [ADDR_W:0]   cubes_used
);

    typedef struct packed {
        logic             en;
        logic [N_IN-1:0]  care;
        logic [N_IN-1:0]  val;
        logic [N_OUT-1:0] out;
    } entry_t;

    entry_t            tbl [N_CUBE];
    entry_t            cur;
    state_t            state, state_n;
    logic [N_IN-1:0]   x_s;
    logic [N_OUT-1:0]  inv_s;
    logic [N_OUT-1:0]  acc;
    logic [N_OUT-1:0]  nacc;
    logic [N_OUT-1:0]  contrib;
    logic [ADDR_W-1:0] idx;
    logic              addr_ok;
    logic              last;

    generate
        if (N_CUBE == (1 << ADDR_W)) begin : g_full_range
            assign addr_ok = 1'b1;
        end else begin : g_part_range
            assign addr_ok = (int'(cube_addr) < N_CUBE);
        end
    endgenerate

    // NOTE: the table is reset with everything else so an empty table evaluates to out_inv
    // straight after reset; that keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CUBE; i++) begin
                tbl[i] <= '0;
            end
        end else if (cube_we && addr_ok) begin
            tbl[cube_addr] <= '{en: cube_en, care: cube_care, val: cube_val, out: cube_out};
        end
    end

    // The entry read here is the registered one, so a same-cycle write to idx is seen only later.
    assign cur = tbl[idx];

    pla_cube_match #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_match (
        .en      (cur.en),
        .care    (cur.care),
        .val     (cur.val),
        .out     (cur.out),
        .x       (x_s),
        .contrib (contrib)
    );

    assign nacc = acc | contrib;
    assign last = (&nacc) || (idx == ADDR_W'(N_CUBE - 1));

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: next state gets its default first so no path through this block infers a latch.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)  state_n = EVAL;
            EVAL:    if (last)      state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_s        <= '0;
            inv_s      <= '0;
            acc        <= '0;
            idx        <= '0;
            y          <= '0;
            cubes_used <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_s        <= x;
                        inv_s      <= out_inv;
                        acc        <= '0;
                        idx        <= '0;
                        cubes_used <= '0;
                    end
                end
                EVAL: begin
                    acc        <= nacc;
                    cubes_used <= {1'b0, idx} + (ADDR_W + 1)'(1);
                    if (last) begin
                        y <= nacc ^ inv_s;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Both handshake outputs come from the state register only, so out_ready never reaches in_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_pla_seq_eval.sv
// Scoreboard bench for pla_seq_eval: one single-output and one dual-output instance.
`timescale 1ns/1ps
module tb_pla_seq_eval;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cube_we;
    logic [AW-1:0] cube_addr;
    logic          cube_en;
    logic [14:0]   cube_care;
    logic [14:0]   cube_val;
    logic          cube_out1;
    logic [1:0]    cube_out2;
    logic [14:0]   x;

    logic          in_valid1, in_ready1, out_valid1, out_ready1, out_inv1, y1;
    logic [AW:0]   used1;
    logic          in_valid2, in_ready2, out_valid2, out_ready2;
    logic [1:0]    out_inv2, y2;
    logic [AW:0]   used2;

    typedef struct {
        logic [1:0] y;
        logic [4:0] used;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    pla_seq_eval #(.N_IN(15), .N_CUBE(16), .N_OUT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cube_we    (cube_we),
        .cube_addr  (cube_addr),
        .cube_en    (cube_en),
        .cube_care  (cube_care),
        .cube_val   (cube_val),
        .cube_out   (cube_out1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .x          (x),
        .out_inv    (out_inv1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .y          (y1),
        .cubes_used (used1)
    );

    pla_seq_eval #(.N_IN(15), .N_CUBE(16), .N_OUT(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cube_we    (cube_we),
        .cube_addr  (cube_addr),
        .cube_en    (cube_en),
        .cube_care  (cube_care),
        .cube_val   (cube_val),
        .cube_out   (cube_out2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .x          (x),
        .out_inv    (out_inv2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .y          (y2),
        .cubes_used (used2)
    );

    // ---------------- stimulus helpers (all return just after a falling edge) ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_cube(input logic [AW-1:0] a, input logic en, input logic [14:0] c,
                              input logic [14:0] v, input logic o1, input logic [1:0] o2);
        cube_we = 1'b1; cube_addr = a; cube_en = en; cube_care = c; cube_val = v;
        cube_out1 = o1; cube_out2 = o2;
        @(negedge clk);
        cube_we = 1'b0;
    endtask

    task automatic offer(input int sel, input logic [14:0] xv, input logic [1:0] inv);
        int n = 0;
        x = xv;
        if (sel == 2) begin
            out_inv2 = inv; in_valid2 = 1'b1;
            while (!in_ready2 && n < 32) begin @(negedge clk); n++; end
        end else begin
            out_inv1 = inv[0]; in_valid1 = 1'b1;
            while (!in_ready1 && n < 32) begin @(negedge clk); n++; end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0; in_valid2 = 1'b0;
    endtask

    task automatic wait_out(input int sel, input int lat0, output int lat,
                            output logic [1:0] oy, output logic [4:0] oused);
        lat = lat0;
        while (!(sel == 2 ? out_valid2 : out_valid1) && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        oy    = (sel == 2) ? y2 : {1'b0, y1};
        oused = (sel == 2) ? used2 : used1;
    endtask

    task automatic release_out(input int sel);
        if (sel == 2) out_ready2 = 1'b1; else out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0; out_ready2 = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int lat; logic [1:0] oy; logic [4:0] ou; exp_t e;
        rst_n = 1'b0;
        #3;
        total++; if ({in_ready1, out_valid1, y1, used1} !== 8'b1000_0000)
            $display("FAIL reset_state: got %b want %b", {in_ready1, out_valid1, y1, used1}, 8'b1000_0000); else passed++;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sbq.push_back('{2'(k), 5'd16, 16});
            offer(1, 15'h0000, 2'(k));
            wait_out(1, 0, lat, oy, ou); e = sbq.pop_front();
            total++; if (oy !== e.y) $display("FAIL empty_y inv=%0d: got %0h want %0h", k, oy, e.y); else passed++;
            total++; if (ou !== e.used) $display("FAIL empty_used inv=%0d: got %0d want %0d", k, ou, e.used); else passed++;
            total++; if (lat !== e.lat) $display("FAIL empty_latency inv=%0d: got %0d want %0d", k, lat, e.lat); else passed++;
            release_out(1);
        end
    endtask

    task automatic test_single_cube();
        int lat; logic [1:0] oy; logic [4:0] ou; exp_t e;
        logic [14:0] xs [3];
        logic [1:0]  inv [3];
        xs[0] = 15'h0120; inv[0] = 2'b00; sbq.push_back('{2'b01, 5'd4,  4});
        xs[1] = 15'h0020; inv[1] = 2'b00; sbq.push_back('{2'b00, 5'd16, 16});
        xs[2] = 15'h0120; inv[2] = 2'b01; sbq.push_back('{2'b00, 5'd4,  4});
        do_reset();
        write_cube(4'd3, 1'b1, 15'h0120, 15'h0120, 1'b1, 2'b00);
        for (int k = 0; k < 3; k++) begin
            offer(1, xs[k], inv[k]);
            wait_out(1, 0, lat, oy, ou); e = sbq.pop_front();
            total++; if (oy !== e.y) $display("FAIL single_y[%0d]: got %0h want %0h", k, oy, e.y); else passed++;
            total++; if (ou !== e.used) $display("FAIL single_used[%0d]: got %0d want %0d", k, ou, e.used); else passed++;
            total++; if (lat !== e.lat) $display("FAIL single_latency[%0d]: got %0d want %0d", k, lat, e.lat); else passed++;
            release_out(1);
        end
    endtask

    task automatic test_early_term();
        int lat; logic [1:0] oy; logic [4:0] ou; exp_t e;
        do_reset();
        write_cube(4'd0, 1'b1, 15'h0, 15'h0, 1'b0, 2'b01);
        write_cube(4'd5, 1'b1, 15'h0, 15'h0, 1'b0, 2'b10);
        for (int k = 0; k < 2; k++) begin
            sbq.push_back('{(k == 0) ? 2'b11 : 2'b10, 5'd6, 6});
            offer(2, 15'($urandom), (k == 0) ? 2'b00 : 2'b01);
            wait_out(2, 0, lat, oy, ou); e = sbq.pop_front();
            total++; if (oy !== e.y) $display("FAIL early_y[%0d]: got %b want %b", k, oy, e.y); else passed++;
            total++; if (ou !== e.used) $display("FAIL early_used[%0d]: got %0d want %0d", k, ou, e.used); else passed++;
            total++; if (lat !== e.lat) $display("FAIL early_latency[%0d]: got %0d want %0d", k, lat, e.lat); else passed++;
            release_out(2);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [1:0] oy; logic [4:0] ou; exp_t e;
        do_reset();
        write_cube(4'd3, 1'b1, 15'h0120, 15'h0120, 1'b1, 2'b00);
        sbq.push_back('{2'b00, 5'd16, 16});
        offer(1, 15'h0020, 2'b00);
        wait_out(1, 0, lat, oy, ou); e = sbq.pop_front();
        total++; if ({oy, ou} !== {e.y, e.used}) $display("FAIL bp_result: got %0h/%0d want %0h/%0d", oy, ou, e.y, e.used); else passed++;
        for (int i = 0; i < 10; i++) begin
            in_valid1 = 1'b1; x = 15'($urandom); out_inv1 = i[0];
            cube_we = 1'b1; cube_addr = AW'(i); cube_en = 1'b1; cube_care = '0; cube_val = '0; cube_out1 = 1'b1;
            @(negedge clk);
            total++; if ({out_valid1, in_ready1, y1, used1} !== {1'b1, 1'b0, 1'b0, 5'd16})
                $display("FAIL bp_hold[%0d]: got %b want %b", i, {out_valid1, in_ready1, y1, used1}, {1'b1, 1'b0, 1'b0, 5'd16}); else passed++;
        end
        cube_we = 1'b0; in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        #1;
        total++; if (in_ready1 !== 1'b0) $display("FAIL bp_no_comb_ready: got %b want 0", in_ready1); else passed++;
        @(negedge clk); out_ready1 = 1'b0;
        total++; if ({in_ready1, out_valid1} !== 2'b10) $display("FAIL bp_release: got %b want 10", {in_ready1, out_valid1}); else passed++;
    endtask

    task automatic test_write_hazard();
        int lat; logic [1:0] oy; logic [4:0] ou; exp_t e;
        do_reset();
        sbq.push_back('{2'b01, 5'd8, 8});
        offer(1, 15'h1234, 2'b00);
        repeat (2) @(negedge clk);
        cube_we = 1'b1; cube_addr = 4'd2; cube_en = 1'b1; cube_care = '0; cube_val = '0; cube_out1 = 1'b1;
        x = 15'h7FFF;
        @(negedge clk);
        cube_addr = 4'd7;
        @(negedge clk);
        cube_we = 1'b0;
        wait_out(1, 4, lat, oy, ou); e = sbq.pop_front();
        total++; if (oy !== e.y) $display("FAIL hazard_y: got %0h want %0h", oy, e.y); else passed++;
        total++; if (ou !== e.used) $display("FAIL hazard_used: got %0d want %0d", ou, e.used); else passed++;
        total++; if (lat !== e.lat) $display("FAIL hazard_latency: got %0d want %0d", lat, e.lat); else passed++;
        release_out(1);
    endtask

    task automatic test_reset_mid();
        int lat; logic [1:0] oy; logic [4:0] ou; exp_t e;
        do_reset();
        write_cube(4'd10, 1'b1, 15'h0, 15'h0, 1'b1, 2'b00);
        sbq.push_back('{2'b01, 5'd11, 11});
        offer(1, 15'h0000, 2'b00);
        wait_out(1, 0, lat, oy, ou); e = sbq.pop_front();
        total++; if ({oy, ou} !== {e.y, e.used}) $display("FAIL mid_pre: got %0h/%0d want %0h/%0d", oy, ou, e.y, e.used); else passed++;
        release_out(1);
        offer(1, 15'h0000, 2'b00);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({out_valid1, in_ready1, y1, used1} !== {1'b0, 1'b1, 1'b0, 5'd0})
            $display("FAIL mid_reset_state: got %b want %b", {out_valid1, in_ready1, y1, used1}, {1'b0, 1'b1, 1'b0, 5'd0}); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        total++; if (out_valid1 !== 1'b0) $display("FAIL mid_no_partial: got %b want 0", out_valid1); else passed++;
        sbq.push_back('{2'b00, 5'd16, 16});
        offer(1, 15'h0000, 2'b00);
        wait_out(1, 0, lat, oy, ou); e = sbq.pop_front();
        total++; if (oy !== e.y) $display("FAIL mid_table_cleared_y: got %0h want %0h", oy, e.y); else passed++;
        total++; if (ou !== e.used) $display("FAIL mid_table_cleared_used: got %0d want %0d", ou, e.used); else passed++;
        release_out(1);
    endtask

    initial begin
        rst_n = 1'b0; cube_we = 1'b0; cube_addr = '0; cube_en = 1'b0; cube_care = '0; cube_val = '0;
        cube_out1 = 1'b0; cube_out2 = '0; x = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; out_inv1 = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; out_inv2 = '0;
        test_reset();
        test_single_cube();
        test_early_term();
        test_backpressure();
        test_write_hazard();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
